// File: rtl/be_clock_input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | be_clock_input_ctrl: sync + debounce of front-panel keys/switch, step      |
// | pulse and saturating speed code. Optional AUTO_REPEAT_EN: held-step repeat. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module be_clock_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       KEY_STEP_N,
  input  logic       KEY_UP_N,
  input  logic       KEY_DN_N,
  input  logic       SW_SELECT,
  output logic       CLK_STEP,
  output logic       CLK_SELECT,
  output logic [2:0] DIV_CLK
);

  localparam logic [CNT_W-1:0] c_deb_term = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Synchronizer reset value is the idle raw level: buttons released, switch low.
  localparam logic [3:0]       c_sync_idle = 4'b0111;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_level;
  logic [3:0] w_stable;
  logic [2:0] r_stable_q;
  logic [2:0] w_press;
  logic       w_step_pulse;
  logic       r_step;
  logic [2:0] r_div;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync1 <= c_sync_idle;
      r_sync2 <= c_sync_idle;
    end else begin
      r_sync1 <= {SW_SELECT, KEY_DN_N, KEY_UP_N, KEY_STEP_N};
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = {r_sync2[3], ~r_sync2[2:0]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      logic [CNT_W-1:0] r_cnt;
      logic             r_state;

      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          r_cnt   <= '0;
          r_state <= 1'b0;
        end else if (w_level[gi] == r_state) begin
          r_cnt <= '0;
        end else if (r_cnt == c_deb_term) begin
          r_state <= w_level[gi];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_stable[gi] = r_state;
    end
  endgenerate

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_stable_q <= 3'b000;
    end else begin
      r_stable_q <= w_stable[2:0];
    end
  end

  assign w_press = w_stable[2:0] & ~r_stable_q;

`ifdef AUTO_REPEAT_EN
  localparam int c_hold_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_hold_w   = $clog2(c_hold_max + 1);

  logic [c_hold_w-1:0] r_hold;
  logic                r_rep_phase;
  logic                w_fire;

  // r_hold counts cycles since the last emitted pulse; first gap is the delay, then the period.
  assign w_fire = w_stable[0] &&
                  (r_rep_phase ? (r_hold == c_hold_w'(REPEAT_PERIOD))
                               : (r_hold == c_hold_w'(REPEAT_DELAY)));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else if (!w_stable[0]) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_fire) begin
      r_hold      <= c_hold_w'(1);
      r_rep_phase <= 1'b1;
    end else begin
      r_hold <= r_hold + c_hold_w'(1);
    end
  end

  assign w_step_pulse = w_press[0] | w_fire;
`else
  assign w_step_pulse = w_press[0];
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_step <= 1'b0;
      r_div  <= 3'd0;
    end else begin
      r_step <= w_step_pulse;
      if (w_press[1] && !w_press[2] && r_div != 3'd7) begin
        r_div <= r_div + 3'd1;
      end else if (w_press[2] && !w_press[1] && r_div != 3'd0) begin
        r_div <= r_div - 3'd1;
      end
    end
  end

  assign CLK_STEP   = r_step;
  assign CLK_SELECT = w_stable[3];
  assign DIV_CLK    = r_div;

endmodule
`default_nettype wire

// File: tb/tb_be_clock_input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_be_clock_input_ctrl: randomized + directed bench with reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_be_clock_input_ctrl;

  localparam int D = 4;
`ifdef AUTO_REPEAT_EN
  localparam int R = 20;
  localparam int P = 8;
`endif

  logic       iCLK       = 1'b0;
  logic       iRST_N     = 1'b0;
  logic       KEY_STEP_N = 1'b1;
  logic       KEY_UP_N   = 1'b1;
  logic       KEY_DN_N   = 1'b1;
  logic       SW_SELECT  = 1'b0;
  logic       CLK_STEP;
  logic       CLK_SELECT;
  logic [2:0] DIV_CLK;

  always #5 iCLK = ~iCLK;

  be_clock_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(R),
    .REPEAT_PERIOD(P)
`endif
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .KEY_STEP_N(KEY_STEP_N),
    .KEY_UP_N(KEY_UP_N),
    .KEY_DN_N(KEY_DN_N),
    .SW_SELECT(SW_SELECT),
    .CLK_STEP(CLK_STEP),
    .CLK_SELECT(CLK_SELECT),
    .DIV_CLK(DIV_CLK)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int tick_no  = 0;
  int pulse_cnt = 0;
  int pulse_ticks[$];
  int sel_first;

  // Reference model: raw samples reach the debouncer two edges later; a level is
  // accepted after D consecutive edges of disagreement with the accepted state.
  logic [3:0] m_pipe0, m_pipe1;
  logic [3:0] m_stab, m_rose;
  int         m_run[4];
  int         m_ecnt, m_t0;
  logic       exp_step, exp_sel;
  int         exp_div;

  task automatic model_reset();
    m_pipe0 = 4'b0111;
    m_pipe1 = 4'b0111;
    m_stab  = 4'b0000;
    m_rose  = 4'b0000;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_ecnt   = 0;
    m_t0     = 0;
    exp_step = 1'b0;
    exp_sel  = 1'b0;
    exp_div  = 0;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic lvl;
    m_ecnt++;
    exp_step = m_rose[0];
`ifdef AUTO_REPEAT_EN
    if (m_stab[0] && m_ecnt > m_t0 && (m_ecnt - m_t0) >= R && ((m_ecnt - m_t0 - R) % P) == 0)
      exp_step = 1'b1;
`endif
    if (m_rose[1] && !m_rose[2] && exp_div < 7) exp_div++;
    else if (m_rose[2] && !m_rose[1] && exp_div > 0) exp_div--;
    for (int i = 0; i < 4; i++) begin
      lvl = (i == 3) ? m_pipe1[i] : ~m_pipe1[i];
      m_rose[i] = 1'b0;
      if (lvl != m_stab[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == D) begin
        m_rose[i] = lvl;
        m_stab[i] = lvl;
        m_run[i]  = 0;
      end
    end
    if (m_rose[0]) m_t0 = m_ecnt + 1;
    m_pipe1 = m_pipe0;
    m_pipe0 = raw;
    exp_sel = m_stab[3];
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", nm, act, exp, tick_no);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
    tick_no++;
    if (!iRST_N) model_reset();
    else model_edge({SW_SELECT, KEY_DN_N, KEY_UP_N, KEY_STEP_N});
    check("clk_step", {31'd0, CLK_STEP}, {31'd0, exp_step});
    check("clk_select", {31'd0, CLK_SELECT}, {31'd0, exp_sel});
    check("div_clk", {29'd0, DIV_CLK}, exp_div);
    if (CLK_STEP === 1'b1) begin
      pulse_cnt++;
      pulse_ticks.push_back(tick_no);
    end
  endtask

  task automatic press_speed(input logic up, input logic dn);
    KEY_UP_N = ~up;
    KEY_DN_N = ~dn;
    repeat (8) tick();
    KEY_UP_N = 1'b1;
    KEY_DN_N = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    int k;
    int hold[4];
    logic [3:0] rv;

    model_reset();
    repeat (3) tick();
    iRST_N = 1'b1;
    repeat (10) tick();

    // Clean press: pulse exactly 6 edges after the first edge seeing the key low.
    pulse_cnt = 0;
    pulse_ticks.delete();
    KEY_STEP_N = 1'b0;
    k = tick_no + 1;
    repeat (12) tick();
    KEY_STEP_N = 1'b1;
    repeat (12) tick();
    check("clean_press_count", pulse_cnt, 1);
    if (pulse_ticks.size() > 0) check("clean_press_edge", pulse_ticks[0] - k, 6);

    // Bounce: 2-cycle toggles never accepted, then one pulse after settling.
    pulse_cnt = 0;
    pulse_ticks.delete();
    for (int b = 0; b < 5; b++) begin
      KEY_STEP_N = 1'b0;
      repeat (2) tick();
      KEY_STEP_N = 1'b1;
      repeat (2) tick();
    end
    check("bounce_no_pulse", pulse_cnt, 0);
    KEY_STEP_N = 1'b0;
    k = tick_no + 1;
    repeat (10) tick();
    check("bounce_settle_count", pulse_cnt, 1);
    if (pulse_ticks.size() > 0) check("bounce_settle_edge", pulse_ticks[0] - k, 6);
    KEY_STEP_N = 1'b1;
    repeat (10) tick();

    // Speed code saturation at both ends and simultaneous press.
    for (int i = 1; i <= 9; i++) begin
      press_speed(1'b1, 1'b0);
      check("div_up_sat", {29'd0, DIV_CLK}, (i < 7) ? i : 7);
    end
    for (int i = 1; i <= 9; i++) begin
      press_speed(1'b0, 1'b1);
      check("div_dn_sat", {29'd0, DIV_CLK}, (i < 7) ? 7 - i : 0);
    end
    for (int i = 0; i < 3; i++) press_speed(1'b1, 1'b0);
    press_speed(1'b1, 1'b1);
    check("div_both_unchanged", {29'd0, DIV_CLK}, 3);

    // Select: accepted 5 edges after the switch is first sampled; 2-cycle glitch ignored.
    SW_SELECT = 1'b1;
    k = tick_no + 1;
    sel_first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (CLK_SELECT === 1'b1 && sel_first < 0) sel_first = tick_no;
    end
    check("select_edge", sel_first - k, 5);
    SW_SELECT = 1'b0;
    repeat (2) tick();
    SW_SELECT = 1'b1;
    repeat (10) tick();
    check("select_glitch", {31'd0, CLK_SELECT}, 1);

    // Reset mid-debounce with step held; one pulse only after a fresh window.
    KEY_STEP_N = 1'b0;
    repeat (3) tick();
    iRST_N = 1'b0;
    #1;
    model_reset();
    check("rst_step", {31'd0, CLK_STEP}, 0);
    check("rst_select", {31'd0, CLK_SELECT}, 0);
    check("rst_div", {29'd0, DIV_CLK}, 0);
    repeat (3) tick();
    pulse_cnt = 0;
    pulse_ticks.delete();
    iRST_N = 1'b1;
    k = tick_no + 1;
    repeat (15) tick();
    check("rst_hold_count", pulse_cnt, 1);
    if (pulse_ticks.size() > 0) check("rst_hold_edge", pulse_ticks[0] - k, 6);
    KEY_STEP_N = 1'b1;
    repeat (10) tick();

`ifdef AUTO_REPEAT_EN
    // Held step: pulses at relative 0, 20, 28, 36, 44, 52, none after release.
    begin
      int exp_rel[6] = '{0, 20, 28, 36, 44, 52};
      int t0;
      pulse_cnt = 0;
      pulse_ticks.delete();
      KEY_STEP_N = 1'b0;
      t0 = -1;
      for (int i = 0; i < 20 && t0 < 0; i++) begin
        tick();
        if (CLK_STEP === 1'b1) t0 = tick_no;
      end
      check("repeat_first_seen", {31'd0, t0 >= 0}, 1);
      while (t0 >= 0 && tick_no < t0 + 52) tick();
      KEY_STEP_N = 1'b1;
      repeat (20) tick();
      check("repeat_count", pulse_cnt, 6);
      for (int i = 0; i < 6; i++)
        if (i < pulse_ticks.size()) check("repeat_rel", pulse_ticks[i] - pulse_ticks[0], exp_rel[i]);
    end
`endif

    // Randomized: independently slewing inputs with occasional resets.
    rv = {SW_SELECT, KEY_DN_N, KEY_UP_N, KEY_STEP_N};
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          rv[i]   = ~rv[i];
          hold[i] = $urandom_range(1, 12);
        end
        hold[i]--;
      end
      {SW_SELECT, KEY_DN_N, KEY_UP_N, KEY_STEP_N} = rv;
      iRST_N = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    iRST_N = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
